tic_tac_toe_game: RTL and testbench



---
 rtl/tic_tac_toe_pkg.sv | 28 ++
 rtl/ttt_win_check.sv | 31 +++
 rtl/tic_tac_toe_game.sv | 105 ++++++++++
 tb/tb_tic_tac_toe_game.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/tic_tac_toe_pkg.sv
// Shared types and constants for the tic-tac-toe controller.
package tic_tac_toe_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned IDX_W     = 4;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef cell_t [NUM_CELLS-1:0] board_t;

    // Cell indices of each winning line, row-major with a=0 .. i=8
    localparam logic [IDX_W-1:0] WIN_LINES [NUM_LINES][3] = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

endpackage

// File: rtl/ttt_win_check.sv
// Combinational win and full-grid detection over the board registers.
module ttt_win_check
    import tic_tac_toe_pkg::*;
(
    input  board_t i_board,
    output logic   o_p1_win,
    output logic   o_p2_win,
    output logic   o_grid_full
);

    always_comb begin
        o_p1_win    = 1'b0;
        o_p2_win    = 1'b0;
        o_grid_full = 1'b1;
        for (int unsigned l = 0; l < NUM_LINES; l++) begin
            if (i_board[WIN_LINES[3'(l)][0]] == P1 &&
                i_board[WIN_LINES[3'(l)][1]] == P1 &&
                i_board[WIN_LINES[3'(l)][2]] == P1)
                o_p1_win = 1'b1;
            if (i_board[WIN_LINES[3'(l)][0]] == P2 &&
                i_board[WIN_LINES[3'(l)][1]] == P2 &&
                i_board[WIN_LINES[3'(l)][2]] == P2)
                o_p2_win = 1'b1;
        end
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            if (i_board[4'(c)] == EMPTY)
                o_grid_full = 1'b0;
        end
    end

endmodule

// File: rtl/tic_tac_toe_game.sv
// Two-player tic-tac-toe controller: press detection, board/turn state,
// blink counter and LED/status decode.
module tic_tac_toe_game
    import tic_tac_toe_pkg::*;
#(
    parameter int unsigned BLINK_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_button,
    input  logic b_button,
    input  logic c_button,
    input  logic d_button,
    input  logic e_button,
    input  logic f_button,
    input  logic g_button,
    input  logic h_button,
    input  logic i_button,
    output logic p1_turn,
    output logic p2_turn,
    output logic p1_win,
    output logic p2_win,
    output logic grid_full,
    output logic a_led,
    output logic b_led,
    output logic c_led,
    output logic d_led,
    output logic e_led,
    output logic f_led,
    output logic g_led,
    output logic h_led,
    output logic i_led
);

    board_t                 r_board;
    logic                   r_turn_p2;
    logic [NUM_CELLS-1:0]   r_btn_q;
    logic [BLINK_W-1:0]     r_blink_cnt;

    logic [NUM_CELLS-1:0]   w_btn;
    logic [NUM_CELLS-1:0]   w_press;
    logic [NUM_CELLS-1:0]   w_empty;
    logic [NUM_CELLS-1:0]   w_led;
    logic                   w_one_hot;
    logic                   w_active;
    logic                   w_valid;
    logic                   w_p1_win;
    logic                   w_p2_win;
    logic                   w_grid_full;

    assign w_btn = {i_button, h_button, g_button, f_button, e_button,
                    d_button, c_button, b_button, a_button};

    assign w_press   = w_btn & ~r_btn_q;
    // Exactly one press: nonzero and clearing the lowest set bit leaves nothing
    assign w_one_hot = (w_press != '0) &&
                       ((w_press & (w_press - NUM_CELLS'(1))) == '0);
    assign w_active  = ~w_p1_win & ~w_p2_win & ~w_grid_full;
    assign w_valid   = w_active & w_one_hot & ((w_press & w_empty) != '0);

    always_comb begin
        w_empty = '0;
        w_led   = '0;
        for (int unsigned c = 0; c < NUM_CELLS; c++) begin
            w_empty[4'(c)] = (r_board[4'(c)] == EMPTY);
            w_led[4'(c)]   = (r_board[4'(c)] == P1) ||
                             ((r_board[4'(c)] == P2) && r_blink_cnt[BLINK_W-1]);
        end
    end

    always_ff @(posedge clk) begin
        r_btn_q <= w_btn;
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CELLS; c++)
                r_board[4'(c)] <= EMPTY;
            r_turn_p2   <= 1'b0;
            r_blink_cnt <= '0;
        end else begin
            r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            if (w_valid) begin
                for (int unsigned c = 0; c < NUM_CELLS; c++) begin
                    if (w_press[4'(c)])
                        r_board[4'(c)] <= r_turn_p2 ? P2 : P1;
                end
                r_turn_p2 <= ~r_turn_p2;
            end
        end
    end

    ttt_win_check u_win_check (
        .i_board     (r_board),
        .o_p1_win    (w_p1_win),
        .o_p2_win    (w_p2_win),
        .o_grid_full (w_grid_full)
    );

    assign p1_win    = w_p1_win;
    assign p2_win    = w_p2_win;
    assign grid_full = w_grid_full;
    assign p1_turn   = w_active & ~r_turn_p2;
    assign p2_turn   = w_active &  r_turn_p2;

    assign {i_led, h_led, g_led, f_led, e_led, d_led, c_led, b_led, a_led} = w_led;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Directed self-checking bench for tic_tac_toe_game.
module tb_tic_tac_toe_game;

    logic       clk;
    logic       rst_n;
    logic [8:0] r_btn;
    logic [8:0] w_leds;
    logic       p1_turn, p2_turn, p1_win, p2_win, grid_full;
    logic       a_led, b_led, c_led, d_led, e_led, f_led, g_led, h_led, i_led;
    logic [4:0] w_status;

    int n_checks;
    int n_pass;

    tic_tac_toe_game #(.BLINK_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_button  (r_btn[0]),
        .b_button  (r_btn[1]),
        .c_button  (r_btn[2]),
        .d_button  (r_btn[3]),
        .e_button  (r_btn[4]),
        .f_button  (r_btn[5]),
        .g_button  (r_btn[6]),
        .h_button  (r_btn[7]),
        .i_button  (r_btn[8]),
        .p1_turn   (p1_turn),
        .p2_turn   (p2_turn),
        .p1_win    (p1_win),
        .p2_win    (p2_win),
        .grid_full (grid_full),
        .a_led     (a_led),
        .b_led     (b_led),
        .c_led     (c_led),
        .d_led     (d_led),
        .e_led     (e_led),
        .f_led     (f_led),
        .g_led     (g_led),
        .h_led     (h_led),
        .i_led     (i_led)
    );

    assign w_leds   = {i_led, h_led, g_led, f_led, e_led, d_led, c_led, b_led, a_led};
    assign w_status = {p1_turn, p2_turn, p1_win, p2_win, grid_full};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic press(input logic [3:0] idx);
        @(negedge clk);
        r_btn[idx] = 1'b1;
        @(negedge clk);
        r_btn[idx] = 1'b0;
    endtask

    // status bits: {p1_turn, p2_turn, p1_win, p2_win, grid_full}
    initial begin
        logic d_hi, d_lo, f_hi, f_lo, abc_steady, df_same;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        r_btn    = '0;

        // P1 win on top row, then frozen
        do_reset();
        check("reset_status", 32'(w_status), 32'b10000);
        check("reset_leds", 32'(w_leds), 32'h000);
        press(4'd0);
        check("after_a_status", 32'(w_status), 32'b01000);
        check("after_a_led", 32'(w_leds[0]), 32'd1);
        press(4'd3);
        check("after_d_status", 32'(w_status), 32'b10000);
        press(4'd1);
        check("after_b_status", 32'(w_status), 32'b01000);
        press(4'd5);
        check("after_f_status", 32'(w_status), 32'b10000);
        press(4'd2);
        check("p1_win_status", 32'(w_status), 32'b00100);
        press(4'd4);
        press(4'd6);
        press(4'd7);
        press(4'd8);
        check("frozen_status", 32'(w_status), 32'b00100);
        check("frozen_leds_eghi", 32'(w_leds & 9'b111010000), 32'h000);
        d_hi = 1'b0; d_lo = 1'b0; f_hi = 1'b0; f_lo = 1'b0;
        abc_steady = 1'b1; df_same = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (w_leds[3]) d_hi = 1'b1; else d_lo = 1'b1;
            if (w_leds[5]) f_hi = 1'b1; else f_lo = 1'b1;
            if (w_leds[2:0] != 3'b111) abc_steady = 1'b0;
            if (w_leds[3] != w_leds[5]) df_same = 1'b0;
        end
        check("abc_steady", 32'(abc_steady), 32'd1);
        check("d_blinks", 32'({d_hi, d_lo}), 32'b11);
        check("f_blinks", 32'({f_hi, f_lo}), 32'b11);
        check("df_in_phase", 32'(df_same), 32'd1);

        // P2 win on middle row
        do_reset();
        press(4'd0); press(4'd3); press(4'd1); press(4'd4); press(4'd8);
        check("p2_pre_win_status", 32'(w_status), 32'b01000);
        press(4'd5);
        check("p2_win_status", 32'(w_status), 32'b00010);

        // Draw
        do_reset();
        press(4'd0); press(4'd1); press(4'd2); press(4'd4);
        press(4'd3); press(4'd5); press(4'd7); press(4'd6);
        check("draw_pre_full_status", 32'(w_status), 32'b10000);
        press(4'd8);
        check("draw_status", 32'(w_status), 32'b00001);

        // Held button fires once
        do_reset();
        @(negedge clk);
        r_btn[1] = 1'b1;
        repeat (5) @(negedge clk);
        r_btn[1] = 1'b0;
        check("hold_status", 32'(w_status), 32'b01000);
        check("hold_leds", 32'(w_leds), 32'h002);
        press(4'd1);
        check("repress_status", 32'(w_status), 32'b01000);
        check("repress_led_b", 32'(w_leds[1]), 32'd1);
        press(4'd0);
        check("after_hold_p2_move", 32'(w_status), 32'b10000);

        // Simultaneous presses ignored
        do_reset();
        @(negedge clk);
        r_btn = 9'b000010001;
        @(negedge clk);
        r_btn = '0;
        check("multi_status", 32'(w_status), 32'b10000);
        check("multi_leds", 32'(w_leds), 32'h000);
        press(4'd0);
        check("multi_then_a", 32'(w_status), 32'b01000);

        // Reset mid-game overrides a press, held button does not fire afterwards
        do_reset();
        press(4'd4);
        press(4'd8);
        @(negedge clk);
        rst_n    = 1'b0;
        r_btn[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_status", 32'(w_status), 32'b10000);
        check("midrst_leds", 32'(w_leds), 32'h000);
        @(negedge clk);
        r_btn[0] = 1'b0;
        check("midrst_held_status", 32'(w_status), 32'b10000);
        check("midrst_held_led_a", 32'(w_leds[0]), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
